// File: rtl/kbd_pkg.sv
// Shared PS/2 scan-code constants, parser state encoding and the stored entry format.
package kbd_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_NORM = 2'd0,
        S_EXT  = 2'd1,
        S_BRK  = 2'd2
    } state_e;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } entry_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head word is driven straight from storage, clear beats push/pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en, rd_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign wr_en   = push_i && !clr_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !clr_i && !empty_o;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (wr_en && !rd_en)      count_d = count_q + CNT_W'(1);
            else if (!wr_en && rd_en) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the empty flag masks stale words, and it maps to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/kbd_scan_sequencer.sv
// PS/2 scan-byte parser (E0/F0 prefixes, repeat filter, prefix timeout) feeding a show-ahead FIFO.
module kbd_scan_sequencer
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter logic [15:0] TIMEOUT       = 16'd50000,
    parameter int unsigned REPEAT_FILTER = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ps2_valid,
    input  logic [7:0]             ps2_data,
    input  logic                   flush,
    input  logic                   dec_ready,
    output logic                   dec_valid,
    output logic [7:0]             dec_data,
    output logic                   dec_ext,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);

    state_e      state_q, state_d;
    logic        ext_pend_q, ext_pend_d;
    entry_t      last_make_q, last_make_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  drop_q, drop_d;
    logic        ovf_q, ovf_d;

    entry_t      push_entry;
    logic        push_req, is_make, repeat_drop, full_drop;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [8:0]  fifo_rdata;

    assign fifo_pop = !fifo_empty && dec_ready && !flush;

    always_comb begin
        state_d     = state_q;
        ext_pend_d  = ext_pend_q;
        last_make_d = last_make_q;
        tmo_d       = tmo_q;
        drop_d      = drop_q;
        ovf_d       = ovf_q;
        push_entry  = '0;
        push_req    = 1'b0;
        is_make     = 1'b0;
        repeat_drop = 1'b0;
        full_drop   = 1'b0;
        fifo_push   = 1'b0;

        if (ps2_valid) begin
            tmo_d = '0;
            unique case (state_q)
                S_NORM: begin
                    if (ps2_data == SC_EXT) begin
                        ext_pend_d = 1'b1;
                        state_d    = S_EXT;
                    end else if (ps2_data == SC_BRK) begin
                        push_req   = 1'b1;
                        push_entry = '{ext: 1'b0, code: SC_BRK};
                        state_d    = S_BRK;
                    end else begin
                        is_make    = 1'b1;
                        push_entry = '{ext: 1'b0, code: ps2_data};
                    end
                end
                S_EXT: begin
                    if (ps2_data == SC_BRK) begin
                        push_req   = 1'b1;
                        push_entry = '{ext: 1'b1, code: SC_BRK};
                        state_d    = S_BRK;
                    end else begin
                        is_make    = 1'b1;
                        push_entry = '{ext: 1'b1, code: ps2_data};
                        ext_pend_d = 1'b0;
                        state_d    = S_NORM;
                    end
                end
                S_BRK: begin
                    push_req   = 1'b1;
                    push_entry = '{ext: ext_pend_q, code: ps2_data};
                    ext_pend_d = 1'b0;
                    state_d    = S_NORM;
                    // A release of the remembered key re-arms the repeat filter for it.
                    if (push_entry == last_make_q) last_make_d = '0;
                end
                default: state_d = S_NORM;
            endcase

            if (is_make) begin
                if ((REPEAT_FILTER != 0) && (push_entry == last_make_q)) begin
                    repeat_drop = 1'b1;
                end else begin
                    push_req    = 1'b1;
                    last_make_d = push_entry;
                end
            end
        end else if (state_q != S_NORM) begin
            if (tmo_q + 16'd1 == TIMEOUT) begin
                state_d    = S_NORM;
                ext_pend_d = 1'b0;
                tmo_d      = '0;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end

        full_drop = push_req && fifo_full && !fifo_pop;
        fifo_push = push_req && !full_drop;
        if (full_drop) ovf_d = 1'b1;
        if (full_drop || repeat_drop) drop_d = sat_inc8(drop_q);

        if (flush) begin
            state_d     = S_NORM;
            ext_pend_d  = 1'b0;
            last_make_d = '0;
            tmo_d       = '0;
            drop_d      = '0;
            ovf_d       = 1'b0;
            fifo_push   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_NORM;
            ext_pend_q  <= 1'b0;
            last_make_q <= '0;
            tmo_q       <= '0;
            drop_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_pend_q  <= ext_pend_d;
            last_make_q <= last_make_d;
            tmo_q       <= tmo_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (9),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign dec_valid = !fifo_empty;
    assign dec_ext   = fifo_rdata[8];
    assign dec_data  = fifo_rdata[7:0];
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_kbd_scan_sequencer.sv
// Directed bench for kbd_scan_sequencer: parser, repeat filter, timeout, FIFO limits, flush and reset.
module tb_kbd_scan_sequencer;

    localparam int unsigned DEPTH   = 8;
    localparam logic [15:0] TIMEOUT = 16'd20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_valid;
    logic [7:0] ps2_data;
    logic       flush;
    logic       dec_ready;
    logic       dec_valid;
    logic [7:0] dec_data;
    logic       dec_ext;
    logic [3:0] fifo_count;
    logic       overflow;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    kbd_scan_sequencer #(
        .DEPTH         (DEPTH),
        .TIMEOUT       (TIMEOUT),
        .REPEAT_FILTER (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_valid  (ps2_valid),
        .ps2_data   (ps2_data),
        .flush      (flush),
        .dec_ready  (dec_ready),
        .dec_valid  (dec_valid),
        .dec_data   (dec_data),
        .dec_ext    (dec_ext),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        ps2_data  = b;
        ps2_valid = 1'b1;
        @(posedge clk); #1;
        ps2_valid = 1'b0;
    endtask

    task automatic pop_one();
        dec_ready = 1'b1;
        @(posedge clk); #1;
        dec_ready = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] makes [10];
    logic [7:0] drain [8];

    initial begin
        makes = '{8'h15, 8'h16, 8'h1D, 8'h1E, 8'h24, 8'h25, 8'h26, 8'h2D, 8'h2E, 8'h36};
        drain = '{8'h16, 8'h1D, 8'h1E, 8'h24, 8'h25, 8'h26, 8'h2D, 8'h3D};
        rst_n = 1'b0; ps2_valid = 1'b0; ps2_data = 8'h00; flush = 1'b0; dec_ready = 1'b0;

        #1;
        check("rst_valid", dec_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Make/break/make streamed with the decoder always ready.
        ps2_data = 8'h1C; ps2_valid = 1'b1; dec_ready = 1'b1;
        #1 check("t1_empty_push_no_valid", dec_valid, 0);
        @(posedge clk); #1;
        check("t1_latency_valid", dec_valid, 1);
        check("t1_head0", {dec_ext, dec_data}, 9'h01C);
        check("t1_count0", fifo_count, 1);
        ps2_data = 8'hF0;
        @(posedge clk); #1;
        check("t1_head1", {dec_ext, dec_data}, 9'h0F0);
        check("t1_count1", fifo_count, 1);
        ps2_data = 8'h1C;
        @(posedge clk); #1;
        check("t1_head2", {dec_ext, dec_data}, 9'h01C);
        ps2_valid = 1'b0;
        @(posedge clk); #1;
        dec_ready = 1'b0;
        check("t1_drained", dec_valid, 0);
        check("t1_drop", drop_cnt, 0);

        // Extended make and extended break.
        send(8'hE0);
        check("t2_e0_not_stored", fifo_count, 0);
        send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        check("t2_count", fifo_count, 3);
        check("t2_e0", {dec_ext, dec_data}, 9'h175); pop_one();
        check("t2_e1", {dec_ext, dec_data}, 9'h1F0); pop_one();
        check("t2_e2", {dec_ext, dec_data}, 9'h175); pop_one();
        check("t2_empty", dec_valid, 0);

        // Typematic repeat suppression.
        send(8'h1C); send(8'h1C); send(8'h1C);
        check("t3_count", fifo_count, 1);
        check("t3_drop", drop_cnt, 2);
        check("t3_ovf", overflow, 0);
        do_flush();
        check("t3_flush_drop", drop_cnt, 0);

        // Fill past full, then push and pop together at full.
        for (int i = 0; i < 10; i++) send(makes[i]);
        check("t4_count_full", fifo_count, 8);
        check("t4_ovf", overflow, 1);
        check("t4_drop", drop_cnt, 2);
        check("t4_head", dec_data, 8'h15);
        ps2_data = 8'h3D; ps2_valid = 1'b1; dec_ready = 1'b1;
        @(posedge clk); #1;
        ps2_valid = 1'b0; dec_ready = 1'b0;
        check("t4_pushpop_count", fifo_count, 8);
        check("t4_pushpop_drop", drop_cnt, 2);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_drain%0d", i), {dec_ext, dec_data}, {1'b0, drain[i]});
            pop_one();
        end
        check("t4_empty_count", fifo_count, 0);

        // Break prefix one cycle short of the timeout: next byte is still a break code.
        do_flush();
        send(8'hF0);
        idle(int'(TIMEOUT) - 1);
        send(8'h1C);
        send(8'h1C);
        check("t5a_count", fifo_count, 3);
        check("t5a_drop", drop_cnt, 0);

        // Break prefix expires: next byte is a make and becomes last_make.
        do_flush();
        send(8'hF0);
        idle(int'(TIMEOUT));
        send(8'h1C);
        check("t5b_count", fifo_count, 2);
        send(8'h1C);
        check("t5b_repeat_drop", drop_cnt, 1);
        check("t5b_head_f0", {dec_ext, dec_data}, 9'h0F0); pop_one();
        check("t5b_head_make", {dec_ext, dec_data}, 9'h01C);

        // Flush in S_EXT with 5 entries and overflow set; flush beats push and pop.
        do_flush();
        for (int i = 0; i < 9; i++) send(makes[i]);
        check("t6_ovf_set", overflow, 1);
        pop_one(); pop_one(); pop_one();
        send(8'hE0);
        check("t6_count5", fifo_count, 5);
        flush = 1'b1; ps2_data = 8'h25; ps2_valid = 1'b1; dec_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ps2_valid = 1'b0; dec_ready = 1'b0;
        check("t6_count", fifo_count, 0);
        check("t6_valid", dec_valid, 0);
        check("t6_ovf", overflow, 0);
        check("t6_drop", drop_cnt, 0);
        send(8'h75);
        check("t6_norm_after", {dec_ext, dec_data}, 9'h075);

        // Asynchronous reset in the middle of an extended sequence.
        send(8'h16);
        send(8'hE0);
        rst_n = 1'b0;
        #2;
        check("t7_rst_count", fifo_count, 0);
        check("t7_rst_valid", dec_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        send(8'h75);
        check("t7_norm_after", {dec_ext, dec_data}, 9'h075);
        check("t7_count", fifo_count, 1);

        // Drop counter saturates at 255.
        do_flush();
        send(8'h1C);
        repeat (260) send(8'h1C);
        check("t8_drop_sat", drop_cnt, 8'hFF);
        check("t8_count", fifo_count, 1);
        check("t8_ovf", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
